hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline hazard controller for the 5-stage RV32I core (IF/ID/EX/MEM/WB).
//  Shadows rd/rs/load info of in-flight insns from decode, and drives the stall,
//  flush and operand-forwarding controls. Sits beside the decoder in ID; outputs
//  go to the PC register, pipeline registers and EX operand muxes.
// PARAMETERS
//  REG_AW  5   register address width
//  CNT_W   16  width of bubble counter o_bubble_cnt
//  MEM_TO  64  max consecutive MEM-wait cycles before o_mem_err
// PORTS
//  i_clk          in   1       clock
//  i_reset        in   1       synchronous reset, active-high
//  i_id_vld       in   1       valid insn in ID
//  i_id_rs1_addr  in   REG_AW  ID rs1
//  i_id_rs1_use   in   1       ID insn reads rs1
//  i_id_rs2_addr  in   REG_AW  ID rs2
//  i_id_rs2_use   in   1       ID insn reads rs2
//  i_id_rd_addr   in   REG_AW  ID rd
//  i_id_rd_wren   in   1       ID insn writes rd
//  i_id_is_load   in   1       ID insn is a load
//  i_id_is_mem    in   1       ID insn is load or store
//  i_ex_redirect  in   1       EX insn is a taken branch/jump
//  i_lsu_ready    in   1       LSU completes MEM-stage access this cycle
//  o_stall_pc     out  1       hold PC
//  o_stall_ifid   out  1       hold IF/ID reg
//  o_stall_back   out  1       hold ID/EX, EX/MEM, MEM/WB regs
//  o_flush_ifid   out  1       IF/ID becomes bubble at next edge
//  o_flush_idex   out  1       ID/EX becomes bubble at next edge
//  o_fwd_a_sel    out  2       EX operand A: 00 regfile, 01 MEM ALU result, 10 WB data
//  o_fwd_b_sel    out  2       EX operand B, same encoding
//  o_mem_err      out  1       sticky: MEM wait exceeded MEM_TO
//  o_bubble_cnt   out  CNT_W   saturating count of bubbles inserted
// BEHAVIOUR
//  - Shadow stages EX, MEM, WB each hold {vld, rd, wren, is_load, is_mem, rs1, rs2};
//    EX captures from ID inputs.
//  - Advance: on each edge, ID->EX->MEM->WB, unless frozen.
//  - Bubble insertion: EX.vld=0 when o_flush_idex=1 or i_id_vld=0.
//  - Reset: all stage vld=0, state RUN, counters 0, o_mem_err=0.
//    All stall/flush/fwd outputs are 0 during the reset cycle and the cycle after.
//  - FSM:
//    RUN -> MEMWAIT when MEM.vld & MEM.is_mem & !i_lsu_ready.
//    MEMWAIT -> RUN on the cycle i_lsu_ready=1.
//  - MEM wait (combinational, in both RUN and MEMWAIT):
//    o_stall_pc=o_stall_ifid=o_stall_back=1; no flushes; shadow stages frozen.
//  - Priority per cycle: MEM wait > redirect > load-use.
//    A redirect held during MEM wait stays asserted by the frozen EX; act on it after.
//  - Redirect (i_ex_redirect & EX.vld, no MEM wait): o_flush_ifid=o_flush_idex=1.
//    Pipeline advances and load-use is ignored for that cycle.
//  - Load-use: EX.vld & EX.is_load & EX.rd!=0 & i_id_vld & ((rs1_use & rs1==EX.rd) | (rs2_use & rs2==EX.rd)).
//    Response: o_stall_pc=o_stall_ifid=1, o_flush_idex=1; exactly 1 bubble per hazard.
//  - Forwarding for the EX insn, per operand X with rsX_use captured:
//    MEM match (MEM.vld & wren & !is_load & rd==rsX & rd!=0) -> 01;
//    else WB match (WB.vld & wren & rd==rsX & rd!=0) -> 10; else 00.
//    MEM has priority over WB. x0 is never forwarded.
//  - o_bubble_cnt increments by 1 for each load-use bubble and each redirect
//    (counts 1 per redirect, not 2); saturates at all-ones.
//  - MEM timeout: wait counter counts consecutive MEMWAIT cycles, cleared on leaving MEMWAIT.
//    Reaching MEM_TO sets o_mem_err (sticky until reset). Stall continues regardless.
//  - Reset mid-MEMWAIT: state RUN, stages invalid, next cycle no stall.
// TESTING
//  - Back-to-back ALU: addi x1; add x2,x1,x1 -> EX fwd_a=fwd_b=01.
//    One insn later, reading x1 -> fwd=10. No stall.
//  - Load-use: lw x5; add x6,x5,x0 -> 1 cycle stall_pc/ifid+flush_idex.
//    Then fwd_a=10; bubble_cnt=1.
//  - x0 dest: addi x0; add x3,x0,x0 -> fwd=00.
//    lw x0 followed by use of x0 -> no stall.
//  - Taken branch in EX with load-use hazard in ID same cycle -> flush_ifid=flush_idex=1.
//    No stall; bubble_cnt +1.
//  - Store in MEM, i_lsu_ready=0 for 3 cycles while EX redirects -> 3 cycles stall_back=1, no flush.
//    Flush in cycle 4.
//  - MEM_TO=4, lsu_ready low 6 cycles -> o_mem_err=1 from 4th wait cycle, sticky.
//    Reset -> 0 and no stall.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the 5-stage RV32I core.
// Shadows the in-flight instructions (EX/MEM/WB) from decode information and
// derives stall, flush and EX operand-forwarding controls.
//
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_id_*                decoded fields of the instruction currently in ID
//   i_ex_redirect         EX instruction is a taken branch/jump
//   i_lsu_ready           LSU completes the MEM-stage access this cycle
//   o_stall_pc/ifid/back  hold PC / IF-ID / back-end pipeline registers
//   o_flush_ifid/idex     turn IF-ID / ID-EX into a bubble at the next edge
//   o_fwd_a_sel/b_sel     EX operand select: 00 regfile, 01 MEM ALU, 10 WB data
//   o_mem_err             sticky MEM-wait timeout flag
//   o_bubble_cnt          saturating count of inserted bubbles
module hazard_ctrl #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned MEM_TO = 64
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_id_vld,
    input  logic [REG_AW-1:0] i_id_rs1_addr,
    input  logic              i_id_rs1_use,
    input  logic [REG_AW-1:0] i_id_rs2_addr,
    input  logic              i_id_rs2_use,
    input  logic [REG_AW-1:0] i_id_rd_addr,
    input  logic              i_id_rd_wren,
    input  logic              i_id_is_load,
    input  logic              i_id_is_mem,
    input  logic              i_ex_redirect,
    input  logic              i_lsu_ready,
    output logic              o_stall_pc,
    output logic              o_stall_ifid,
    output logic              o_stall_back,
    output logic              o_flush_ifid,
    output logic              o_flush_idex,
    output logic [1:0]        o_fwd_a_sel,
    output logic [1:0]        o_fwd_b_sel,
    output logic              o_mem_err,
    output logic [CNT_W-1:0]  o_bubble_cnt
);

    localparam int unsigned WCNT_W = $clog2(MEM_TO + 1);

    // Later stages keep only the fields something downstream still consumes:
    // operand addresses matter only while the insn sits in EX, load/mem flags
    // only up to MEM.
    typedef struct packed {
        logic              vld;
        logic [REG_AW-1:0] rd;
        logic              wren;
        logic              is_load;
        logic              is_mem;
        logic [REG_AW-1:0] rs1;
        logic              rs1_use;
        logic [REG_AW-1:0] rs2;
        logic              rs2_use;
    } ex_stage_t;

    typedef struct packed {
        logic              vld;
        logic [REG_AW-1:0] rd;
        logic              wren;
        logic              is_load;
        logic              is_mem;
    } mem_stage_t;

    typedef struct packed {
        logic              vld;
        logic [REG_AW-1:0] rd;
        logic              wren;
    } wb_stage_t;

    typedef enum logic {
        ST_RUN,
        ST_MEMWAIT
    } state_t;

    ex_stage_t   ex_q,  ex_d;
    mem_stage_t  mem_q, mem_d;
    wb_stage_t   wb_q,  wb_d;
    state_t      state_q, state_d;
    logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_err_q, mem_err_d;
    logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

    logic mem_wait;
    logic redirect;
    logic load_use;
    logic timeout_now;

    function automatic logic [1:0] fwd_sel(
        input logic              vld,
        input logic              use_rs,
        input logic [REG_AW-1:0] rs,
        input mem_stage_t        m,
        input wb_stage_t         w
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (vld && use_rs && rs != '0) begin
            if (m.vld && m.wren && !m.is_load && m.rd == rs)
                sel = 2'b01;
            else if (w.vld && w.wren && w.rd == rs)
                sel = 2'b10;
        end
        return sel;
    endfunction

    always_comb begin
        // Every control is gated by reset so the reset cycle itself is quiet.
        mem_wait = !i_reset && mem_q.vld && mem_q.is_mem && !i_lsu_ready;
        redirect = !i_reset && !mem_wait && i_ex_redirect && ex_q.vld;
        load_use = !i_reset && !mem_wait && !redirect && ex_q.vld && ex_q.is_load &&
                   (ex_q.rd != '0) && i_id_vld &&
                   ((i_id_rs1_use && i_id_rs1_addr == ex_q.rd) ||
                    (i_id_rs2_use && i_id_rs2_addr == ex_q.rd));

        // wait_cnt_q holds the number of wait cycles already completed, so the
        // current cycle is wait number wait_cnt_q+1.
        timeout_now = mem_wait && (32'(wait_cnt_q) + 32'd1 >= MEM_TO);

        o_stall_pc   = mem_wait || load_use;
        o_stall_ifid = mem_wait || load_use;
        o_stall_back = mem_wait;
        o_flush_ifid = redirect;
        o_flush_idex = redirect || load_use;
        o_fwd_a_sel  = i_reset ? 2'b00 : fwd_sel(ex_q.vld, ex_q.rs1_use, ex_q.rs1, mem_q, wb_q);
        o_fwd_b_sel  = i_reset ? 2'b00 : fwd_sel(ex_q.vld, ex_q.rs2_use, ex_q.rs2, mem_q, wb_q);
        o_mem_err    = mem_err_q || timeout_now;
        o_bubble_cnt = bubble_cnt_q;

        mem_err_d = o_mem_err;

        bubble_cnt_d = bubble_cnt_q;
        if ((redirect || load_use) && bubble_cnt_q != '1)
            bubble_cnt_d = bubble_cnt_q + 1'b1;

        state_d = state_q;
        case (state_q)
            ST_RUN:     if (mem_wait) state_d = ST_MEMWAIT;
            ST_MEMWAIT: if (i_lsu_ready) state_d = ST_RUN;
            default:    state_d = ST_RUN;
        endcase

        wait_cnt_d = '0;
        if (mem_wait) begin
            if (state_q == ST_RUN)
                wait_cnt_d = WCNT_W'(1);
            else if (wait_cnt_q != WCNT_W'(MEM_TO))
                wait_cnt_d = wait_cnt_q + 1'b1;
            else
                wait_cnt_d = wait_cnt_q;
        end

        ex_d  = ex_q;
        mem_d = mem_q;
        wb_d  = wb_q;
        if (!mem_wait) begin
            wb_d.vld      = mem_q.vld;
            wb_d.rd       = mem_q.rd;
            wb_d.wren     = mem_q.wren;
            mem_d.vld     = ex_q.vld;
            mem_d.rd      = ex_q.rd;
            mem_d.wren    = ex_q.wren;
            mem_d.is_load = ex_q.is_load;
            mem_d.is_mem  = ex_q.is_mem;
            ex_d.vld      = i_id_vld && !o_flush_idex;
            ex_d.rd       = i_id_rd_addr;
            ex_d.wren     = i_id_rd_wren;
            ex_d.is_load  = i_id_is_load;
            ex_d.is_mem   = i_id_is_mem;
            ex_d.rs1      = i_id_rs1_addr;
            ex_d.rs1_use  = i_id_rs1_use;
            ex_d.rs2      = i_id_rs2_addr;
            ex_d.rs2_use  = i_id_rs2_use;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ex_q         <= '0;
            mem_q        <= '0;
            wb_q         <= '0;
            state_q      <= ST_RUN;
            wait_cnt_q   <= '0;
            mem_err_q    <= 1'b0;
            bubble_cnt_q <= '0;
        end else begin
            ex_q         <= ex_d;
            mem_q        <= mem_d;
            wb_q         <= wb_d;
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            mem_err_q    <= mem_err_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    localparam int TO  = 4;
    localparam int CW  = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_vld, rs1_use, rs2_use, rd_wren, is_load, is_mem;
    logic [4:0] rs1, rs2, rd;
    logic       ex_redirect, lsu_ready;
    logic       stall_pc, stall_ifid, stall_back, flush_ifid, flush_idex, mem_err;
    logic [1:0] fwd_a, fwd_b;
    logic [CW-1:0] bubble_cnt;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_AW(5), .CNT_W(CW), .MEM_TO(TO)) dut (
        .i_clk(clk), .i_reset(rst), .i_id_vld(id_vld),
        .i_id_rs1_addr(rs1), .i_id_rs1_use(rs1_use),
        .i_id_rs2_addr(rs2), .i_id_rs2_use(rs2_use),
        .i_id_rd_addr(rd), .i_id_rd_wren(rd_wren),
        .i_id_is_load(is_load), .i_id_is_mem(is_mem),
        .i_ex_redirect(ex_redirect), .i_lsu_ready(lsu_ready),
        .o_stall_pc(stall_pc), .o_stall_ifid(stall_ifid), .o_stall_back(stall_back),
        .o_flush_ifid(flush_ifid), .o_flush_idex(flush_idex),
        .o_fwd_a_sel(fwd_a), .o_fwd_b_sel(fwd_b),
        .o_mem_err(mem_err), .o_bubble_cnt(bubble_cnt)
    );

    typedef struct {
        bit vld, wr, ld, mm, u1, u2;
        int rd, rs1, rs2;
    } ins_t;

    typedef struct {
        int spc, sif, sbk, fif, fex, fa, fb, err, bub;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;
    bit stim_done = 0;

    // Reference model: the three in-flight instructions plus summary counters.
    ins_t m_ex, m_mem, m_wb;
    bit   m_err;
    int   m_bub;
    int   m_wrun;   // length of the current run of consecutive wait cycles

    function automatic ins_t nop();
        ins_t n;
        n = '{default: 0};
        return n;
    endfunction

    function automatic ins_t mk(bit vld, int rd_, bit wr, bit ld, bit mm,
                                int r1, bit u1, int r2, bit u2);
        ins_t n;
        n.vld = vld; n.rd = rd_; n.wr = wr; n.ld = ld; n.mm = mm;
        n.rs1 = r1; n.u1 = u1; n.rs2 = r2; n.u2 = u2;
        return n;
    endfunction

    function automatic int model_fwd(int r, bit u);
        if (!m_ex.vld || !u || r == 0) return 0;
        if (m_mem.vld && m_mem.wr && !m_mem.ld && m_mem.rd == r) return 1;
        if (m_wb.vld && m_wb.wr && m_wb.rd == r) return 2;
        return 0;
    endfunction

    task automatic check(string name, int act, int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // One clock of stimulus: drive inputs just after the edge, predict the
    // outputs for this cycle, queue them, then advance the model to the next edge.
    task automatic cycle(ins_t id, bit redir, bit rdy, bit r);
        exp_t e;
        bit wt, rd_act, lu;
        @(posedge clk);
        #1;
        rst = r;
        id_vld = id.vld; rd = 5'(id.rd); rd_wren = id.wr; is_load = id.ld; is_mem = id.mm;
        rs1 = 5'(id.rs1); rs1_use = id.u1; rs2 = 5'(id.rs2); rs2_use = id.u2;
        ex_redirect = redir; lsu_ready = rdy;

        wt     = !r && m_mem.vld && m_mem.mm && !rdy;
        rd_act = !r && !wt && redir && m_ex.vld;
        lu     = !r && !wt && !rd_act && m_ex.vld && m_ex.ld && m_ex.rd != 0 && id.vld &&
                 ((id.u1 && id.rs1 == m_ex.rd) || (id.u2 && id.rs2 == m_ex.rd));
        e.spc = int'(wt || lu);
        e.sif = int'(wt || lu);
        e.sbk = int'(wt);
        e.fif = int'(rd_act);
        e.fex = int'(rd_act || lu);
        e.fa  = r ? 0 : model_fwd(m_ex.rs1, m_ex.u1);
        e.fb  = r ? 0 : model_fwd(m_ex.rs2, m_ex.u2);
        e.err = int'(m_err || (wt && m_wrun + 1 >= TO));
        e.bub = m_bub;
        q.push_back(e);

        if (r) begin
            m_ex = nop(); m_mem = nop(); m_wb = nop();
            m_err = 0; m_bub = 0; m_wrun = 0;
        end else begin
            m_err  = e.err != 0;
            m_wrun = wt ? m_wrun + 1 : 0;
            if (!wt) begin
                m_wb  = m_mem;
                m_mem = m_ex;
                m_ex  = id;
                if (rd_act || lu) m_ex.vld = 0;
                if ((rd_act || lu) && m_bub < (1 << CW) - 1) m_bub++;
            end
        end
    endtask

    // Monitor: every cycle the DUT presents a full set of controls.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("stall_pc",   int'(stall_pc),   e.spc);
                check("stall_ifid", int'(stall_ifid), e.sif);
                check("stall_back", int'(stall_back), e.sbk);
                check("flush_ifid", int'(flush_ifid), e.fif);
                check("flush_idex", int'(flush_idex), e.fex);
                check("fwd_a",      int'(fwd_a),      e.fa);
                check("fwd_b",      int'(fwd_b),      e.fb);
                check("mem_err",    int'(mem_err),    e.err);
                check("bubble_cnt", int'(bubble_cnt), e.bub);
            end
        end
    end

    initial begin
        ins_t n, addi1, add2, rd1, lw5, use5, addi0, add0, lw0, use0, lw9, use9, sw, br, ri;
        int budget;
        m_ex = nop(); m_mem = nop(); m_wb = nop();
        m_err = 0; m_bub = 0; m_wrun = 0;
        rst = 1; id_vld = 0; rd = 0; rd_wren = 0; is_load = 0; is_mem = 0;
        rs1 = 0; rs1_use = 0; rs2 = 0; rs2_use = 0; ex_redirect = 0; lsu_ready = 1;

        n     = nop();
        addi1 = mk(1, 1, 1, 0, 0, 0, 0, 0, 0);
        add2  = mk(1, 2, 1, 0, 0, 1, 1, 1, 1);
        rd1   = mk(1, 3, 1, 0, 0, 1, 1, 1, 1);
        lw5   = mk(1, 5, 1, 1, 1, 2, 1, 0, 0);
        use5  = mk(1, 6, 1, 0, 0, 5, 1, 0, 1);
        addi0 = mk(1, 0, 1, 0, 0, 0, 0, 0, 0);
        add0  = mk(1, 3, 1, 0, 0, 0, 1, 0, 1);
        lw0   = mk(1, 0, 1, 1, 1, 2, 1, 0, 0);
        use0  = mk(1, 4, 1, 0, 0, 0, 1, 0, 1);
        lw9   = mk(1, 9, 1, 1, 1, 2, 1, 0, 0);
        use9  = mk(1, 7, 1, 0, 0, 9, 1, 0, 0);
        sw    = mk(1, 0, 0, 0, 1, 2, 1, 3, 1);
        br    = mk(1, 0, 0, 0, 0, 1, 1, 2, 1);

        cycle(n, 0, 1, 1);
        cycle(n, 0, 1, 1);
        cycle(n, 0, 1, 0);
        // back-to-back ALU forwarding: MEM (01) then WB (10)
        cycle(addi1, 0, 1, 0); cycle(add2, 0, 1, 0); cycle(rd1, 0, 1, 0);
        cycle(n, 0, 1, 0); cycle(n, 0, 1, 0);
        // load-use: one stall, then WB forward
        cycle(lw5, 0, 1, 0); cycle(use5, 0, 1, 0); cycle(use5, 0, 1, 0);
        cycle(n, 0, 1, 0); cycle(n, 0, 1, 0);
        // x0 is never forwarded nor a load-use source
        cycle(addi0, 0, 1, 0); cycle(add0, 0, 1, 0); cycle(n, 0, 1, 0);
        cycle(lw0, 0, 1, 0); cycle(use0, 0, 1, 0); cycle(n, 0, 1, 0); cycle(n, 0, 1, 0);
        // redirect beats load-use in the same cycle
        cycle(lw9, 0, 1, 0); cycle(use9, 1, 1, 0); cycle(n, 0, 1, 0); cycle(n, 0, 1, 0);
        // store waits in MEM while the branch behind it redirects
        cycle(sw, 0, 1, 0); cycle(br, 0, 1, 0);
        for (int i = 0; i < 3; i++) cycle(n, 1, 0, 0);
        cycle(n, 1, 1, 0); cycle(n, 0, 1, 0); cycle(n, 0, 1, 0);
        // timeout: six wait cycles, flag sticky until reset
        cycle(sw, 0, 1, 0); cycle(n, 0, 1, 0);
        for (int i = 0; i < 6; i++) cycle(n, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(n, 0, 1, 0);
        cycle(n, 0, 1, 1); cycle(n, 0, 1, 0);
        // reset in the middle of a wait
        cycle(sw, 0, 1, 0); cycle(n, 0, 1, 0);
        cycle(n, 0, 0, 0); cycle(n, 0, 0, 0); cycle(n, 0, 0, 1); cycle(n, 0, 0, 0);
        cycle(n, 0, 1, 0);

        for (int i = 0; i < 800; i++) begin
            int kind;
            kind = int'($urandom_range(0, 5));
            ri = mk($urandom_range(0, 5) != 0, int'($urandom_range(0, 3)), 1, 0, 0,
                    int'($urandom_range(0, 3)), $urandom_range(0, 1) != 0,
                    int'($urandom_range(0, 3)), $urandom_range(0, 1) != 0);
            if (kind < 2) begin ri.ld = 1; ri.mm = 1; end
            else if (kind == 2) begin ri.mm = 1; ri.wr = 0; end
            cycle(ri, $urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 149) == 0);
        end

        budget = 20;
        while (q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        stim_done = 1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
